// File: rtl/lsu_sequencer.sv
// Load/store sequencer: alignment check, lane enables, store replication, dmem req/ack handshake, load extension.
// Optional define LSU_TIMEOUT_EN builds an ack-wait timeout that faults the access with code 11.

module lsu_sequencer #(
   parameter int bitwidth = 32,
   parameter int TIMEOUT  = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                op_valid,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [2:0]          funct3,
   input  logic [bitwidth-1:0] addr,
   input  logic [bitwidth-1:0] wdata,
   output logic                stall,
   output logic                done,
   output logic [bitwidth-1:0] rdata,
   output logic                err_valid,
   output logic [1:0]          err_code,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [bitwidth-1:0] dmem_addr,
   output logic [3:0]          dmem_be,
   output logic [bitwidth-1:0] dmem_wdata,
   input  logic                dmem_ack,
   input  logic [bitwidth-1:0] dmem_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

   state_t      state_q;
   logic [29:0] waddr_q;
   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic        sext_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [1:0]  err_code_q;
`ifdef LSU_TIMEOUT_EN
   logic [7:0]  tmo_cnt_q;
`else
   // Deliberately unsinked: the timeout depth has no meaning without the counter.
   logic [7:0]  unused_timeout;
   assign unused_timeout = 8'(TIMEOUT);
`endif

   // Decode of the operation offered in IDLE; these are the values latched on accept.
   logic        f3_legal_d;
   logic        misaligned_d;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      f3_legal_d = 1'b0;
      case (funct3)
         3'b000, 3'b001, 3'b010: f3_legal_d = 1'b1;
         3'b100, 3'b101:         f3_legal_d = mem_read;
         default:                f3_legal_d = 1'b0;
      endcase
      misaligned_d = ((funct3[1:0] == 2'b01) & addr[0]) |
                     ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
      be_d    = 4'b1111;
      wdata_d = wdata;
      case (funct3[1:0])
         2'b00: begin
            be_d    = 4'b0001 << addr[1:0];
            wdata_d = {4{wdata[7:0]}};
         end
         2'b01: begin
            be_d    = 4'b0011 << addr[1:0];
            wdata_d = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   logic [31:0] lane_word;
   logic [31:0] load_ext;

   always_comb begin
      lane_word = dmem_rdata >> {lane_q, 3'b000};
      case (size_q)
         2'b00:   load_ext = {{24{sext_q & lane_word[7]}}, lane_word[7:0]};
         2'b01:   load_ext = {{16{sext_q & lane_word[15]}}, lane_word[15:0]};
         default: load_ext = lane_word;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; datapath latches are reset too so every output is 0 out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         waddr_q    <= '0;
         lane_q     <= '0;
         size_q     <= '0;
         sext_q     <= 1'b0;
         we_q       <= 1'b0;
         be_q       <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_code_q <= '0;
`ifdef LSU_TIMEOUT_EN
         tmo_cnt_q  <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (op_valid && mem_read && mem_write) begin
                  state_q    <= ERR;
                  err_code_q <= 2'b10;
               end else if (op_valid && (mem_read || mem_write)) begin
                  if (!f3_legal_d) begin
                     state_q    <= ERR;
                     err_code_q <= 2'b10;
                  end else if (misaligned_d) begin
                     state_q    <= ERR;
                     err_code_q <= 2'b01;
                  end else begin
                     state_q <= REQ;
                     waddr_q <= addr[31:2];
                     lane_q  <= addr[1:0];
                     size_q  <= funct3[1:0];
                     sext_q  <= ~funct3[2];
                     we_q    <= mem_write;
                     be_q    <= be_d;
                     wdata_q <= wdata_d;
`ifdef LSU_TIMEOUT_EN
                     tmo_cnt_q <= '0;
`endif
                  end
               end
            end
            REQ: begin
               // An ack in the expiry cycle still completes the access.
               if (dmem_ack) begin
                  state_q <= RESP;
                  rdata_q <= we_q ? 32'h0 : load_ext;
               end
`ifdef LSU_TIMEOUT_EN
               else if (tmo_cnt_q == 8'(TIMEOUT - 1)) begin
                  state_q    <= ERR;
                  err_code_q <= 2'b11;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 8'd1;
               end
`endif
            end
            RESP:    state_q <= IDLE;
            ERR:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stall      = (state_q == REQ) |
                       ((state_q == IDLE) & op_valid & (mem_read | mem_write));
   assign done       = (state_q == RESP);
   assign err_valid  = (state_q == ERR);
   assign err_code   = err_code_q;
   assign rdata      = rdata_q;
   assign dmem_req   = (state_q == REQ);
   assign dmem_we    = (state_q == REQ) & we_q;
   assign dmem_addr  = {waddr_q, 2'b00};
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Scoreboard bench for lsu_sequencer: stimulus queues expected responses, a monitor compares done/err pulses.
// Timeout vectors run only when LSU_TIMEOUT_EN is defined.

module tb_lsu_sequencer;

   localparam int TO = 4;

   typedef struct {
      logic        is_err;
      logic [1:0]  code;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        op_valid = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        stall;
   logic        done;
   logic [31:0] rdata;
   logic        err_valid;
   logic [1:0]  err_code;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = 32'h0;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];

   lsu_sequencer #(.bitwidth(32), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .mem_read(mem_read),
      .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
      .stall(stall), .done(done), .rdata(rdata), .err_valid(err_valid),
      .err_code(err_code), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every done/err pulse must match the oldest queued expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset && (done || err_valid)) begin
         if (sb.size() == 0) begin
            check("unexpected_response", {30'd0, done, err_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("resp_is_err", 32'(err_valid), 32'(e.is_err));
            check("resp_is_done", 32'(done), 32'(!e.is_err));
            check("resp_cycle", 32'(cyc), 32'(e.cyc));
            if (e.is_err) check("resp_err_code", 32'(err_code), 32'(e.code));
            else          check("resp_rdata", rdata, e.rdata);
         end
      end
   end

   task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
      op_valid  = 1'b1;
      mem_read  = rd;
      mem_write = wr;
      funct3    = f3;
      addr      = a;
      wdata     = wd;
   endtask

   task automatic clear_op();
      op_valid  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
   endtask

   task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int n_ack,
                         input logic [31:0] word, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
      exp_t e;
      @(negedge clk);
      drive_op(rd, wr, f3, a, wd);
      e.is_err = 1'b0;
      e.code   = 2'b00;
      e.rdata  = exp_rdata;
      e.cyc    = cyc + n_ack + 1;
      sb.push_back(e);
      #1 check({tag, "_stall_accept"}, 32'(stall), 32'd1);
      for (int k = 1; k <= n_ack; k++) begin
         @(negedge clk);
         clear_op();
         check({tag, "_req"}, 32'(dmem_req), 32'd1);
         check({tag, "_we"}, 32'(dmem_we), 32'(wr));
         check({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
         check({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
         check({tag, "_stall_req"}, 32'(stall), 32'd1);
         if (wr) check({tag, "_wdata"}, dmem_wdata, exp_wdata);
         if (k == n_ack) begin
            dmem_ack   = 1'b1;
            dmem_rdata = word;
         end
      end
      @(negedge clk);
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h5A5A_5A5A;
      check({tag, "_stall_resp"}, 32'(stall), 32'd0);
   endtask

   task automatic fault(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [1:0] code);
      exp_t e;
      @(negedge clk);
      drive_op(rd, wr, f3, a, 32'h0);
      e.is_err = 1'b1;
      e.code   = code;
      e.rdata  = 32'h0;
      e.cyc    = cyc + 1;
      sb.push_back(e);
      #1 check({tag, "_stall_accept"}, 32'(stall), 32'd1);
      @(negedge clk);
      clear_op();
      check({tag, "_no_req"}, 32'(dmem_req), 32'd0);
      check({tag, "_stall_err"}, 32'(stall), 32'd0);
      @(negedge clk);
      check({tag, "_code_hold"}, 32'(err_code), 32'(code));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin : stim
      #2;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_err_valid", 32'(err_valid), 32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      check("rst_dmem_req", 32'(dmem_req), 32'd0);
      check("rst_dmem_we", 32'(dmem_we), 32'd0);
      check("rst_dmem_addr", dmem_addr, 32'd0);
      check("rst_dmem_be", 32'(dmem_be), 32'd0);
      check("rst_dmem_wdata", dmem_wdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      access("lbu", 1, 0, 3'b100, 32'h0000_1003, 32'h0, 3, 32'h80FF_1234, 4'b1000, 32'h0, 32'h0000_0080);
      access("lb",  1, 0, 3'b000, 32'h0000_1003, 32'h0, 3, 32'h80FF_1234, 4'b1000, 32'h0, 32'hFFFF_FF80);
      access("sh",  0, 1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 2, 32'h0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
      fault("lw_misalign", 1, 0, 3'b010, 32'h0000_3001, 2'b01);
      access("lh",  1, 0, 3'b001, 32'h0000_4002, 32'h0, 1, 32'h8001_7F00, 4'b1100, 32'h0, 32'hFFFF_8001);
      check("err_code_held", 32'(err_code), 32'd1);
      fault("f3_011", 1, 0, 3'b011, 32'h0000_0000, 2'b10);
      fault("both_strobes", 1, 1, 3'b010, 32'h0000_0000, 2'b10);
      fault("store_f3_100", 0, 1, 3'b100, 32'h0000_0000, 2'b10);
      fault("sh_misalign", 0, 1, 3'b001, 32'h0000_2001, 2'b01);
      access("lhu", 1, 0, 3'b101, 32'h0000_4000, 32'h0, 2, 32'h8001_F00F, 4'b0011, 32'h0, 32'h0000_F00F);
      access("sb",  0, 1, 3'b000, 32'h0000_5001, 32'h1234_56A5, 1, 32'h0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
      access("sw",  0, 1, 3'b010, 32'h0000_6000, 32'hCAFE_F00D, 1, 32'h0, 4'b1111, 32'hCAFE_F00D, 32'h0);
      access("lw_ack4", 1, 0, 3'b010, 32'h0000_7004, 32'h0, TO, 32'h89AB_CDEF, 4'b1111, 32'h0, 32'h89AB_CDEF);

`ifdef LSU_TIMEOUT_EN
      begin : timeout_case
         exp_t e;
         @(negedge clk);
         drive_op(1, 0, 3'b010, 32'h0000_8000, 32'h0);
         e.is_err = 1'b1;
         e.code   = 2'b11;
         e.rdata  = 32'h0;
         e.cyc    = cyc + TO + 1;
         sb.push_back(e);
         for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            clear_op();
            check("tmo_req_held", 32'(dmem_req), 32'd1);
         end
         @(negedge clk);
         check("tmo_req_dropped", 32'(dmem_req), 32'd0);
      end
`else
      access("lw_slow", 1, 0, 3'b010, 32'h0000_8000, 32'h0, 20, 32'h0BAD_F00D, 4'b1111, 32'h0, 32'h0BAD_F00D);
`endif

      // op_valid without strobes and a stray ack in IDLE must both be ignored.
      @(negedge clk);
      op_valid = 1'b1;
      #1 check("idle_nostrobe_stall", 32'(stall), 32'd0);
      @(negedge clk);
      op_valid = 1'b0;
      check("idle_nostrobe_no_req", 32'(dmem_req), 32'd0);
      dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
      check("idle_ack_no_req", 32'(dmem_req), 32'd0);

      // Reset in the middle of REQ, then a late ack.
      @(negedge clk);
      drive_op(1, 0, 3'b010, 32'h0000_9000, 32'h0);
      @(negedge clk);
      clear_op();
      check("rstreq_req_before", 32'(dmem_req), 32'd1);
      @(negedge clk);
      #1 reset = 1'b1;
      #1 check("rstreq_req_drop", 32'(dmem_req), 32'd0);
      check("rstreq_stall_drop", 32'(stall), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      dmem_ack = 1'b0;
      check("late_ack_no_done", 32'(done), 32'd0);
      access("lw_after_rst", 1, 0, 3'b010, 32'h0000_0000, 32'h0, 1, 32'h1122_3344, 4'b1111, 32'h0, 32'h1122_3344);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/lsu_sequencer.md
# lsu_sequencer

Multi-cycle load/store sequencer between the core's execute stage and the data memory. It accepts one memory operation at a time from the control path: read/write strobes, funct3 and the ALU-computed address. It checks alignment, generates lane byte-enables and replicated write data, and runs a req/ack handshake to memory. Load data is sign- or zero-extended, and the core is stalled until the operation completes or faults.

## Interface
- `bitwidth`, 32: data/address width; only 32 is supported.
- `TIMEOUT`, 15: maximum cycles spent waiting for `dmem_ack` before the access faults; range 1..255.

Ports:
- `clk` in 1: clock, rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `op_valid` in 1: operation present this cycle; sampled only in IDLE.
- `mem_read` in 1: load request.
- `mem_write` in 1: store request.
- `funct3` in 3: access size/sign.
- `addr` in 32: byte address.
- `wdata` in 32: store data, taken from the low bits.
- `stall` out 1: hold the core pipeline.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load result, valid while `done`=1.
- `err_valid` out 1: one-cycle fault pulse.
- `err_code` out 2: fault code; 01 misaligned, 10 illegal op, 11 timeout.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: write request.
- `dmem_addr` out 32: word address, with `{addr[31:2],2'b00}`.
- `dmem_be` out 4: byte-lane enables.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_ack` in 1: memory accepted the write or returned the read.
- `dmem_rdata` in 32: full read word, valid with `dmem_ack`.

## Operation
- FSM states are IDLE, REQ, RESP and ERR. Reset state is IDLE.
- IDLE accepts an operation when `op_valid`=1 and `mem_read`^`mem_write`=1.
  - `op_valid` with neither strobe is ignored.
  - `op_valid` with both strobes goes to ERR with code 10.
- Legal funct3 values:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 goes to ERR with code 10.
- Alignment: halfword accesses need `addr[0]`=0; word accesses need `addr[1:0]`=0. A misaligned access goes to ERR with code 01 and makes no memory access.
- A legal access latches addr, size, sign, we and wdata, then goes to REQ.
- Byte enables: byte → `4'b0001<<addr[1:0]`; half → `4'b0011<<addr[1:0]`; word → `4'b1111`.
- Store data: byte is replicated ×4, half ×2, word passes through unchanged.
- REQ holds `dmem_req`=1 and keeps all `dmem_*` outputs stable until `dmem_ack`.
  - On ack, load lanes are selected by the latched `addr[1:0]`, extended per funct3 and registered into `rdata`; the FSM goes to RESP. Stores leave `rdata` at 0.
- RESP: `done`=1 for one cycle, then IDLE.
- ERR: `err_valid`=1 for one cycle, then IDLE.
- `stall` = (state==REQ) | (IDLE & `op_valid` & (`mem_read`|`mem_write`)). It is low in RESP and ERR.

## Timing
- Reset value of every output is 0, and `rdata` = 0.
- Reset mid-REQ drops `dmem_req` immediately. An ack that arrives later in IDLE is ignored.
- Accept happens in cycle 0 and REQ starts in cycle 1. With ack in cycle N ≥ 1, `done` is high in cycle N+1. Minimum latency is 2 cycles.
- Faults detected in IDLE assert `err_valid` in cycle 1.
- `dmem_ack` outside REQ is ignored.
- `op_valid` outside IDLE is ignored; the core is stalled by then.
- Timeout counter:
  - clears on entry to REQ and increments each REQ cycle without ack;
  - reaching `TIMEOUT` goes to ERR with code 11 and deasserts `dmem_req`;
  - if ack arrives in the expiry cycle, the ack wins and the access completes normally.
- `err_code` holds its last value until the next fault. Reset clears it to 00.

## Configuration
- `LSU_TIMEOUT_EN` defined: the timeout counter and code 11 behave as described above.
- `LSU_TIMEOUT_EN` undefined: no counter is built, REQ waits for `dmem_ack` indefinitely, and code 11 is never produced. `TIMEOUT` is then unused.

## Test plan
- LBU with addr=0x1003, memory word 0x80FF_1234 acked after 3 cycles: `dmem_be`=1000, `dmem_addr`=0x1000, `done` 4 cycles after accept, `rdata`=0x0000_0080; the same access as LB gives 0xFFFF_FF80.
- SH with addr=0x2002, wdata=0xDEAD_BEEF: `dmem_we`=1, `dmem_be`=1100, `dmem_wdata`=0xBEEF_BEEF, held stable until ack; `done` one cycle after ack; `stall` high from accept until ack.
- LW with addr=0x3001: no `dmem_req`; `err_valid` in cycle 1 with code 01. funct3=011 gives code 10; both strobes set gives code 10.
- With `LSU_TIMEOUT_EN` and `TIMEOUT`=4, an access with no ack raises code 11 after 4 REQ cycles and `dmem_req` drops. Ack on exactly the 4th cycle gives `done` and no error.
- Assert `reset` during REQ: `dmem_req` and `stall` go to 0 asynchronously. An ack arriving after reset is released produces no `done`. The next LW at 0x0 completes normally.
